fetch_unit: RTL and testbench

Parametrised, decoupled instruction-fetch stage. It replaces the single-cycle PC + combinational memory + "+4" fetch path. It drives a request/response instruction-memory port with multiple requests in flight and buffers returned instructions with their PCs in a FIFO. Decode drains the FIFO via valid/ready. A redirect from execute (branch/jump) changes the PC and flushes all wrong-path work.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited request/response memory port, an
// in-order queue of outstanding request PCs, and an instruction buffer for decode.
module fetch_unit #(
   parameter int unsigned     XLEN       = 32,
   parameter int unsigned     ILEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int unsigned     FIFO_DEPTH = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ILEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc
);

   localparam int unsigned     AW         = $clog2(FIFO_DEPTH);
   localparam int unsigned     CW         = AW + 1;
   localparam logic [CW:0]     DEPTH_EXT  = (CW+1)'(FIFO_DEPTH);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [AW-1:0]   PTR_ONE    = AW'(1);
   localparam logic [CW-1:0]   CNT_ZERO   = '0;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   discard_q, discard_d;

   logic [XLEN-1:0] pcq_mem_q [FIFO_DEPTH];
   logic [AW-1:0]   pcq_wr_q, pcq_wr_d;
   logic [AW-1:0]   pcq_rd_q, pcq_rd_d;

   logic [XLEN-1:0] buf_pc_q    [FIFO_DEPTH];
   logic [ILEN-1:0] buf_instr_q [FIFO_DEPTH];
   logic [AW-1:0]   buf_wr_q, buf_wr_d;
   logic [AW-1:0]   buf_rd_q, buf_rd_d;
   logic [CW-1:0]   buf_cnt_q, buf_cnt_d;

   logic credit_ok_s;
   logic req_fire_s;
   logic rsp_ok_s;
   logic drop_s;
   logic keep_s;
   logic buf_push_s;
   logic pop_s;

   // Slots already owed to the buffer (in flight) plus slots occupied bound new requests.
   assign credit_ok_s    = ({1'b0, inflight_q} + {1'b0, buf_cnt_q}) < DEPTH_EXT;
   assign imem_req_valid = reset && !redirect_valid && credit_ok_s;
   assign imem_req_addr  = pc_q;
   assign req_fire_s     = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is ignored so counters cannot underflow.
   assign rsp_ok_s   = imem_rsp_valid && (inflight_q != CNT_ZERO);
   assign drop_s     = rsp_ok_s && (discard_q != CNT_ZERO);
   assign keep_s     = rsp_ok_s && (discard_q == CNT_ZERO);
   assign buf_push_s = keep_s && !redirect_valid;

   assign out_valid = (buf_cnt_q != CNT_ZERO);
   assign pop_s     = out_valid && out_ready;
   assign out_instr = out_valid ? buf_instr_q[buf_rd_q] : '0;
   assign out_pc    = out_valid ? buf_pc_q[buf_rd_q] : '0;

   // Next-state for PC, counters and queue pointers.
   always_comb begin
      pc_d       = pc_q;
      inflight_d = inflight_q;
      discard_d  = discard_q;
      pcq_wr_d   = pcq_wr_q;
      pcq_rd_d   = pcq_rd_q;
      buf_wr_d   = buf_wr_q;
      buf_rd_d   = buf_rd_q;
      buf_cnt_d  = buf_cnt_q;
      if (redirect_valid) begin
         // Everything still outstanding belongs to the old path and must be dropped.
         pc_d       = redirect_pc & ALIGN_MASK;
         inflight_d = inflight_q - CW'(rsp_ok_s);
         discard_d  = inflight_q - CW'(rsp_ok_s);
         pcq_rd_d   = pcq_wr_q;
         buf_rd_d   = buf_wr_q;
         buf_cnt_d  = CNT_ZERO;
      end else begin
         inflight_d = inflight_q + CW'(req_fire_s) - CW'(rsp_ok_s);
         discard_d  = discard_q - CW'(drop_s);
         buf_cnt_d  = buf_cnt_q + CW'(keep_s) - CW'(pop_s);
         if (req_fire_s) begin
            pc_d     = pc_q + PC_STEP;
            pcq_wr_d = pcq_wr_q + PTR_ONE;
         end else begin
            pc_d     = pc_q;
            pcq_wr_d = pcq_wr_q;
         end
         if (keep_s) begin
            pcq_rd_d = pcq_rd_q + PTR_ONE;
            buf_wr_d = buf_wr_q + PTR_ONE;
         end else begin
            pcq_rd_d = pcq_rd_q;
            buf_wr_d = buf_wr_q;
         end
         if (pop_s) begin
            buf_rd_d = buf_rd_q + PTR_ONE;
         end else begin
            buf_rd_d = buf_rd_q;
         end
      end
   end

   // State registers and queue storage.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q        <= RESET_PC;
         inflight_q  <= '0;
         discard_q   <= '0;
         pcq_wr_q    <= '0;
         pcq_rd_q    <= '0;
         buf_wr_q    <= '0;
         buf_rd_q    <= '0;
         buf_cnt_q   <= '0;
         pcq_mem_q   <= '{default: '0};
         buf_pc_q    <= '{default: '0};
         buf_instr_q <= '{default: '0};
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         pcq_wr_q   <= pcq_wr_d;
         pcq_rd_q   <= pcq_rd_d;
         buf_wr_q   <= buf_wr_d;
         buf_rd_q   <= buf_rd_d;
         buf_cnt_q  <= buf_cnt_d;
         if (req_fire_s) begin
            pcq_mem_q[pcq_wr_q] <= pc_q;
         end
         if (buf_push_s) begin
            buf_pc_q[buf_wr_q]    <= pcq_mem_q[pcq_rd_q];
            buf_instr_q[buf_wr_q] <= imem_rsp_data;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written redirect/reset sequences,
// and a randomized run against an epoch-tagged model of the fetch stream.
module tb_fetch_unit;

   localparam int D = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        req_valid;
   logic        req_ready = 1'b1;
   logic [31:0] req_addr;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_data = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   logic        t_zero = 1'b0;
   logic        t_one = 1'b1;
   logic [31:0] t_word = 32'h0;
   logic        r2_req_valid, r2_out_valid;
   logic [31:0] r2_req_addr, r2_out_instr, r2_out_pc;

   fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(D)) dut (
      .clock(clock), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
   );

   fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(D)) dut_wrap (
      .clock(clock), .reset(reset),
      .redirect_valid(t_zero), .redirect_pc(t_word),
      .imem_req_valid(r2_req_valid), .imem_req_ready(t_one), .imem_req_addr(r2_req_addr),
      .imem_rsp_valid(t_zero), .imem_rsp_data(t_word),
      .out_valid(r2_out_valid), .out_ready(t_zero), .out_instr(r2_out_instr), .out_pc(r2_out_pc)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          due;
      logic [31:0] addr;
      int          epoch;
   } mem_e_t;

   typedef struct {
      bit          do_rst;
      bit          o_ready;
      bit          exp_rv;
      logic [31:0] exp_addr;
      bit          exp_ov;
      logic [31:0] exp_pc;
   } vec_t;

   mem_e_t      memq[$];
   logic [31:0] buf_q[$];
   vec_t        vecs[$];
   int          epoch, cyc, last_due, lat_min, lat_max;
   logic [31:0] exp_req_pc;
   int          n_checks = 0;
   int          n_err = 0;

   logic        s_rv, s_ov, s2_rv;
   logic [31:0] s_addr, s_pc, s_instr, s2_addr;
   int          s_cyc;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[7:0], ~a[15:8], a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   // One clock cycle: sample and compare mid-cycle, advance the model, then drive the memory.
   task automatic step();
      bit     exp_rv, fire, ofire;
      mem_e_t e;
      int     due;
      @(negedge clock);
      s_rv = req_valid; s_addr = req_addr; s_ov = out_valid; s_pc = out_pc; s_instr = out_instr;
      s2_rv = r2_req_valid; s2_addr = r2_req_addr; s_cyc = cyc;
      chk("out_valid", 32'(s_ov), 32'(buf_q.size() != 0));
      if (buf_q.size() != 0) begin
         chk("out_pc", s_pc, buf_q[0]);
         chk("out_instr", s_instr, instr_of(buf_q[0]));
      end
      exp_rv = !redirect_valid && ((memq.size() + buf_q.size()) < D);
      chk("req_valid", 32'(s_rv), 32'(exp_rv));
      chk("req_addr", s_addr, exp_req_pc);
      fire  = exp_rv && req_ready;
      ofire = (buf_q.size() != 0) && out_ready;
      if (ofire) void'(buf_q.pop_front());
      if (rsp_valid && memq.size() != 0) begin
         e = memq.pop_front();
         if (!redirect_valid && e.epoch == epoch) buf_q.push_back(e.addr);
      end
      if (fire) begin
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         memq.push_back('{due, exp_req_pc, epoch});
         last_due = due;
         exp_req_pc = exp_req_pc + 32'd4;
      end
      if (redirect_valid) begin
         epoch++;
         buf_q.delete();
         exp_req_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      @(posedge clock);
      #1;
      cyc++;
      if (memq.size() != 0 && memq[0].due <= cyc) begin
         rsp_valid = 1'b1;
         rsp_data  = instr_of(memq[0].addr);
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = $urandom;
      end
   endtask

   // Asynchronous reset held for one cycle; the memory model shares the reset.
   task automatic apply_reset(input int lmin, input int lmax);
      reset = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0; req_ready = 1'b1;
      rsp_valid = 1'b0; rsp_data = 32'h0;
      memq.delete(); buf_q.delete();
      epoch = 0; last_due = -1; lat_min = lmin; lat_max = lmax; exp_req_pc = 32'h0;
      #2;
      chk("rst_req_valid", 32'(req_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_req_addr", req_addr, 32'h0);
      chk("rst_wrap_addr", r2_req_addr, 32'hFFFF_FFF8);
      @(posedge clock);
      #1;
      reset = 1'b1;
      cyc = 0;
   endtask

   task automatic wait_first_out(input logic [31:0] exp_pc, input int exp_cyc, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (s_ov) found = 1'b1;
      end
      if (found) begin
         chk({tag, "_first_pc"}, s_pc, exp_pc);
         chk({tag, "_first_cycle"}, 32'(s_cyc), 32'(exp_cyc));
      end else begin
         chk({tag, "_out_timeout"}, 32'(s_ov), 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // Ideal memory from reset, decode always ready.
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC});
      // Decode stalled for ten cycles: four requests, then credits run out.
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0});
      for (int i = 0; i < 6; i++) vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'hC});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10});

      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].do_rst) apply_reset(1, 1);
         out_ready = vecs[i].o_ready;
         step();
         chk($sformatf("vec%0d_req_valid", i), 32'(s_rv), 32'(vecs[i].exp_rv));
         chk($sformatf("vec%0d_req_addr", i), s_addr, vecs[i].exp_addr);
         chk($sformatf("vec%0d_out_valid", i), 32'(s_ov), 32'(vecs[i].exp_ov));
         if (vecs[i].exp_ov) chk($sformatf("vec%0d_out_pc", i), s_pc, vecs[i].exp_pc);
      end

      // PC wrap from a reset vector near the top of the address space.
      apply_reset(1, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("wrap_addr%0d", i), s2_addr, 32'hFFFF_FFF8 + 32'(4 * i));
         chk($sformatf("wrap_valid%0d", i), 32'(s2_rv), 32'(i < 4));
      end

      // Redirect with three requests outstanding on a 3-cycle memory.
      apply_reset(3, 3);
      out_ready = 1'b1;
      repeat (3) step();
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      step();
      chk("lat3_no_req_on_redirect", 32'(s_rv), 32'd0);
      redirect_valid = 1'b0;
      step();
      chk("lat3_target_req_valid", 32'(s_rv), 32'd1);
      chk("lat3_target_req_addr", s_addr, 32'h100);
      wait_first_out(32'h100, 8, "lat3");

      // Redirect colliding with a response, followed by a second redirect.
      apply_reset(2, 2);
      out_ready = 1'b1;
      repeat (4) step();
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      step();
      chk("dbl_no_req_first", 32'(s_rv), 32'd0);
      redirect_pc = 32'h80;
      step();
      chk("dbl_no_req_second", 32'(s_rv), 32'd0);
      chk("dbl_flushed_out_valid", 32'(s_ov), 32'd0);
      redirect_valid = 1'b0;
      step();
      chk("dbl_target_req_addr", s_addr, 32'h80);
      wait_first_out(32'h80, 9, "dbl");

      // Redirect-to-output latency with single-cycle memory.
      apply_reset(1, 1);
      out_ready = 1'b1;
      repeat (2) step();
      redirect_valid = 1'b1; redirect_pc = 32'h202;
      step();
      redirect_valid = 1'b0;
      step();
      chk("lat1_target_req_addr", s_addr, 32'h200);
      step();
      chk("lat1_n2_out_valid", 32'(s_ov), 32'd0);
      step();
      chk("lat1_n3_out_valid", 32'(s_ov), 32'd1);
      chk("lat1_n3_out_pc", s_pc, 32'h200);

      // Reset mid-stream with requests in flight and a non-empty buffer.
      apply_reset(3, 3);
      out_ready = 1'b0;
      repeat (6) step();
      chk("midrst_pre_out_valid", 32'(s_ov), 32'd1);
      apply_reset(3, 3);
      out_ready = 1'b1;
      step();
      chk("midrst_restart_addr", s_addr, 32'h0);
      chk("midrst_restart_valid", 32'(s_rv), 32'd1);
      wait_first_out(32'h0, 4, "midrst");

      // Randomized traffic: variable latency, back-pressure and random redirects.
      apply_reset(1, 4);
      for (int i = 0; i < 3000; i++) begin
         req_ready      = ($urandom_range(3, 0) != 0);
         out_ready      = ($urandom_range(3, 0) != 0);
         redirect_valid = ($urandom_range(19, 0) == 0);
         redirect_pc    = $urandom;
         step();
      end
      redirect_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
